divisor_mantiza: RTL and testbench
==================================

# divisor_mantiza

Sequential mantissa divider for the team's 8-bit-mantissa floating-point format with an implicit leading 1. It is the inverse operation of the combinational mantissa multiplier. It computes (1.m1)/(1.m2) by restoring division, one quotient bit per clock. It returns the normalised 8-bit fraction plus an exponent-adjust flag that the exponent path consumes. It sits beside the multiplier in the FP arithmetic datapath, behind a valid/ready handshake on each side.

## Interface
- NB_MANTIZA, 8, stored fraction bits (implicit 1 not stored); all widths below derive from it
- i_clk  input  1  single clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_valid  input  1  operands valid
- o_ready  output  1  divider can accept operands (high only in IDLE)
- i_mantiza_1  input  NB_MANTIZA  dividend fraction m1
- i_mantiza_2  input  NB_MANTIZA  divisor fraction m2
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result
- o_mantiza  output  NB_MANTIZA  normalised quotient fraction, truncated
- o_aviso_exponente  output  1  1 means quotient < 1; exponent path must decrement by 1
- o_inexacto  output  1  present only with DIVISOR_MANTIZA_INEXACTO_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready = 1.
  - On i_valid: latch N = {1,m1} and D = {1,m2}, each NB_MANTIZA+1 bits.
  - Set remainder R = N (NB_MANTIZA+2 bits). Clear quotient Q (NB_MANTIZA+2 bits). Clear counter. Go to RUN.
- RUN, one iteration per cycle, NB_MANTIZA+2 iterations (10 by default):
  - bit = (R >= D).
  - R = (bit ? R-D : R) << 1.
  - Q = {Q, bit}.
  - Counter uses ceil(log2(NB_MANTIZA+2)) bits. After the last iteration go to DONE.
- R never exceeds 2D-1, so NB_MANTIZA+2 bits suffice and no overflow can occur.
- Normalisation, registered on entry to DONE:
  - Q[MSB]=1 (m1 >= m2, quotient in [1,2)): o_mantiza = Q[MSB-1:1], o_aviso_exponente = 0.
  - Q[MSB]=0 (quotient in (0.5,1)): o_mantiza = Q[MSB-2:0], o_aviso_exponente = 1.
- Truncation only, no rounding. The divisor cannot be zero because of the implicit 1, so there is no divide-by-zero case.
- DONE:
  - o_valid = 1. Outputs stay stable while i_ready = 0.
  - When i_ready = 1: go to IDLE.
- o_ready is 0 in RUN and DONE. i_valid is ignored there, and operand inputs may change freely.

## Timing
- Accept at edge T (IDLE, i_valid=1). Iterations occur at edges T+1..T+10. o_valid is high after edge T+10.
- Latency from accept edge to o_valid is NB_MANTIZA+2 cycles.
- Result handshake completes at the edge where o_valid & i_ready. o_ready is high after that edge.
- Throughput: minimum NB_MANTIZA+4 cycles per operation. No accept happens in the same cycle as a result handshake.
- Reset (asynchronous, any state, including mid-RUN or DONE):
  - State goes to IDLE and any partial result is discarded.
  - o_valid=0, o_mantiza=0, o_aviso_exponente=0, o_inexacto=0.
  - Q, R and the counter are cleared. o_ready=1 while i_rst_n is low and after release.

## Configuration
- DIVISOR_MANTIZA_INEXACTO_EN defined:
  - Adds the o_inexacto port, registered on entry to DONE.
  - o_inexacto = (final R != 0) or (Q[0]=1 and o_aviso_exponente=0), i.e. any truncated bit is nonzero.
  - Reset value 0.
- Macro not defined: the port and its logic are absent. All other behaviour and timing are identical.

## Structure
- Shared package `fp_pkg`: NB_MANTIZA default and the derived widths (quotient/remainder NB_MANTIZA+2, counter width). It is shared with the multiplier.
- The FSM state typedef stays local.
- One natural sub-module: `paso_division`, a combinational single restoring step. Inputs R and D; outputs the quotient bit and the next R.

## Test plan
- m1=0x00, m2=0x00 (1.0/1.0) -> o_mantiza=0x00, o_aviso_exponente=0, o_inexacto=0; o_valid exactly 10 cycles after accept.
- m1=0x80, m2=0x00 (1.5/1.0) -> 0x80, aviso=0, inexacto=0.
- m1=0x00, m2=0x80 (1.0/1.5) -> 0x55, aviso=1, inexacto=1.
- m1=0xFF, m2=0x00 -> 0xFF, aviso=0.
- m1=0x00, m2=0xFF -> 0x00, aviso=1, inexacto=1.
- Protocol stress:
  - Hold i_ready=0 for 5 cycles in DONE with i_valid=1 and changing operands -> outputs stable, o_ready=0, no new accept.
  - Assert i_rst_n=0 mid-RUN (iteration 4) -> immediate IDLE, all outputs 0.
  - After reset, the next operation (0x80/0x00) returns the correct result.

Source files
------------

// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared widths for the 8-bit-mantissa floating-point datapath (multiplier and
// divider). The stored fraction excludes the implicit leading 1.
//   NB_MANTIZA  : stored fraction bits
//   NB_OPERANDO : fraction plus implicit 1
//   NB_COCIENTE : quotient bits produced by the divider (one guard + one spare)
//   NB_RESTO    : partial remainder width (holds up to 2*D-1)
//   NB_CONTADOR : iteration counter width
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int NB_MANTIZA  = 8;
  localparam int NB_OPERANDO = NB_MANTIZA + 1;
  localparam int NB_COCIENTE = NB_MANTIZA + 2;
  localparam int NB_RESTO    = NB_MANTIZA + 2;
  localparam int NB_CONTADOR = $clog2(NB_COCIENTE);

endpackage

// File: rtl/paso_division.sv
// -----------------------------------------------------------------------------
// paso_division
// One combinational restoring-division step.
//   i_resto      : current partial remainder R
//   i_divisor    : divisor D = {1, m2}
//   o_bit        : quotient bit, (R >= D)
//   o_resto_next : (bit ? R - D : R) << 1
// -----------------------------------------------------------------------------
module paso_division
  import fp_pkg::*;
(
  input  logic [NB_RESTO-1:0]    i_resto,
  input  logic [NB_OPERANDO-1:0] i_divisor,
  output logic                   o_bit,
  output logic [NB_RESTO-1:0]    o_resto_next
);

  logic [NB_RESTO-1:0] divisor_ext;
  logic [NB_RESTO-1:0] resto_sel;

  always_comb begin
    divisor_ext  = {{(NB_RESTO-NB_OPERANDO){1'b0}}, i_divisor};
    o_bit        = (i_resto >= divisor_ext);
    resto_sel    = o_bit ? (i_resto - divisor_ext) : i_resto;
    // resto_sel < D, so its top bit is always 0 and the shift never overflows.
    o_resto_next = resto_sel << 1;
  end

endmodule

// File: rtl/divisor_mantiza.sv
// -----------------------------------------------------------------------------
// divisor_mantiza
// Sequential mantissa divider: (1.m1)/(1.m2) by restoring division, one
// quotient bit per clock, NB_MANTIZA+2 iterations. Returns the normalised,
// truncated fraction and a flag telling the exponent path to decrement.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_valid / o_ready  : operand handshake (o_ready high only in IDLE)
//   i_mantiza_1/2      : dividend / divisor fractions
//   o_valid / i_ready  : result handshake
//   o_mantiza          : normalised quotient fraction
//   o_aviso_exponente  : 1 when quotient < 1 (exponent must drop by 1)
//   o_inexacto         : any truncated bit nonzero; only present when the
//                        DIVISOR_MANTIZA_INEXACTO_EN macro is defined
// -----------------------------------------------------------------------------
module divisor_mantiza
  import fp_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [NB_MANTIZA-1:0] i_mantiza_1,
  input  logic [NB_MANTIZA-1:0] i_mantiza_2,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [NB_MANTIZA-1:0] o_mantiza,
`ifdef DIVISOR_MANTIZA_INEXACTO_EN
  output logic                  o_inexacto,
`endif
  output logic                  o_aviso_exponente
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} estado_t;

  localparam logic [NB_CONTADOR-1:0] ULTIMA_ITER = NB_CONTADOR'(NB_COCIENTE - 1);

  estado_t                 estado_reg, estado_next;
  logic [NB_RESTO-1:0]     resto_reg;
  logic [NB_COCIENTE-1:0]  cociente_reg;
  logic [NB_OPERANDO-1:0]  divisor_reg;
  logic [NB_CONTADOR-1:0]  contador_reg;
  logic [NB_MANTIZA-1:0]   mantiza_reg;
  logic                    aviso_reg;

  logic                    bit_q;
  logic [NB_RESTO-1:0]     resto_next;
  logic [NB_COCIENTE-1:0]  cociente_next;
  logic [NB_MANTIZA-1:0]   mantiza_norm;
  logic                    aviso_norm;
  logic                    ultima;

  paso_division u_paso (
    .i_resto      (resto_reg),
    .i_divisor    (divisor_reg),
    .o_bit        (bit_q),
    .o_resto_next (resto_next)
  );

  // Normalisation is taken from the quotient including the bit being produced
  // this cycle, so the outputs are ready on the same edge that enters DONE.
  always_comb begin
    cociente_next = (cociente_reg << 1) | {{(NB_COCIENTE-1){1'b0}}, bit_q};
    ultima        = (contador_reg == ULTIMA_ITER);
    if (cociente_next[NB_COCIENTE-1]) begin
      mantiza_norm = cociente_next[NB_COCIENTE-2:1];
      aviso_norm   = 1'b0;
    end else begin
      mantiza_norm = cociente_next[NB_COCIENTE-3:0];
      aviso_norm   = 1'b1;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) estado_reg <= IDLE;
    else          estado_reg <= estado_next;
  end

  // Next state and handshake outputs
  always_comb begin
    estado_next = estado_reg;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    case (estado_reg)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) estado_next = RUN;
      end
      RUN: begin
        if (ultima) estado_next = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) estado_next = IDLE;
      end
      default: estado_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      resto_reg    <= '0;
      cociente_reg <= '0;
      divisor_reg  <= '0;
      contador_reg <= '0;
      mantiza_reg  <= '0;
      aviso_reg    <= 1'b0;
    end else begin
      case (estado_reg)
        IDLE: begin
          if (i_valid) begin
            divisor_reg  <= {1'b1, i_mantiza_2};
            resto_reg    <= {1'b0, 1'b1, i_mantiza_1};
            cociente_reg <= '0;
            contador_reg <= '0;
          end
        end
        RUN: begin
          resto_reg    <= resto_next;
          cociente_reg <= cociente_next;
          contador_reg <= contador_reg + NB_CONTADOR'(1);
          if (ultima) begin
            mantiza_reg <= mantiza_norm;
            aviso_reg   <= aviso_norm;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIVISOR_MANTIZA_INEXACTO_EN
  logic inexacto_reg;

  // Inexact when the leftover remainder is nonzero, or when normalisation by a
  // right shift drops a set quotient LSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inexacto_reg <= 1'b0;
    end else if (estado_reg == RUN && ultima) begin
      inexacto_reg <= (resto_next != '0) ||
                      (cociente_next[0] && cociente_next[NB_COCIENTE-1]);
    end
  end

  assign o_inexacto = inexacto_reg;
`endif

  assign o_mantiza         = mantiza_reg;
  assign o_aviso_exponente = aviso_reg;

endmodule

// File: tb/tb_divisor_mantiza.sv
// -----------------------------------------------------------------------------
// tb_divisor_mantiza
// Self-checking bench for divisor_mantiza with a scoreboard queue of expected
// results computed from integer division of the full mantissas.
// -----------------------------------------------------------------------------
module tb_divisor_mantiza;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_mantiza_1 = '0;
  logic [7:0] i_mantiza_2 = '0;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic [7:0] o_mantiza;
  logic       o_aviso_exponente;
`ifdef DIVISOR_MANTIZA_INEXACTO_EN
  logic       o_inexacto;
`endif

  always #5 i_clk = ~i_clk;

  divisor_mantiza dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .i_mantiza_1       (i_mantiza_1),
    .i_mantiza_2       (i_mantiza_2),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_mantiza         (o_mantiza),
`ifdef DIVISOR_MANTIZA_INEXACTO_EN
    .o_inexacto        (o_inexacto),
`endif
    .o_aviso_exponente (o_aviso_exponente)
  );

  typedef struct {
    logic [7:0] mantiza;
    logic       aviso;
    logic       inexacto;
  } resultado_t;

  resultado_t esperados[$];
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_valor(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: quotient = floor((1.m1 / 1.m2) * 512) over 10 bits.
  function automatic resultado_t modelo(input logic [7:0] m1, input logic [7:0] m2);
    resultado_t r;
    int n, d, q, rem;
    n   = 256 + int'(m1);
    d   = 256 + int'(m2);
    q   = (n * 512) / d;
    rem = (n * 512) % d;
    if (q >= 512) begin
      r.mantiza  = 8'((q >> 1) & 255);
      r.aviso    = 1'b0;
      r.inexacto = (rem != 0) || ((q & 1) != 0);
    end else begin
      r.mantiza  = 8'(q & 255);
      r.aviso    = 1'b1;
      r.inexacto = (rem != 0);
    end
    return r;
  endfunction

  // Accept one operation; returns once the accept edge has passed.
  task automatic aceptar(input logic [7:0] m1, input logic [7:0] m2);
    int espera;
    espera = 0;
    @(negedge i_clk);
    while (!o_ready && espera < 30) begin
      @(negedge i_clk);
      espera++;
    end
    check_valor("ready_before_accept", {31'b0, o_ready}, 32'd1);
    i_mantiza_1 = m1;
    i_mantiza_2 = m2;
    i_valid     = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Full transaction with optional back-pressure in DONE.
  task automatic operacion(input logic [7:0] m1, input logic [7:0] m2, input int espera_done);
    int ciclos;
    resultado_t e;
    esperados.push_back(modelo(m1, m2));
    aceptar(m1, m2);
    ciclos = 0;
    while (ciclos < 40) begin
      @(posedge i_clk);
      #1;
      ciclos++;
      if (o_valid) break;
    end
    check_valor("valid_seen", {31'b0, o_valid}, 32'd1);
    check_valor("latency", 32'(ciclos), 32'd10);
    e = esperados.pop_front();
    for (int k = 0; k < espera_done; k++) begin
      @(negedge i_clk);
      i_valid     = 1'b1;
      i_mantiza_1 = 8'($urandom);
      i_mantiza_2 = 8'($urandom);
      @(posedge i_clk);
      #1;
      check_valor("hold_valid", {31'b0, o_valid}, 32'd1);
      check_valor("hold_ready", {31'b0, o_ready}, 32'd0);
      check_valor("hold_mantiza", {24'b0, o_mantiza}, {24'b0, e.mantiza});
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    check_valor("mantiza", {24'b0, o_mantiza}, {24'b0, e.mantiza});
    check_valor("aviso", {31'b0, o_aviso_exponente}, {31'b0, e.aviso});
`ifdef DIVISOR_MANTIZA_INEXACTO_EN
    check_valor("inexacto", {31'b0, o_inexacto}, {31'b0, e.inexacto});
`endif
    $display("op m1=0x%02h m2=0x%02h -> mantiza=0x%02h aviso=%0d (exp 0x%02h/%0d)",
             m1, m2, o_mantiza, o_aviso_exponente, e.mantiza, e.aviso);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    check_valor("post_handshake_valid", {31'b0, o_valid}, 32'd0);
    check_valor("post_handshake_ready", {31'b0, o_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check_valor("rst_ready", {31'b0, o_ready}, 32'd1);
    check_valor("rst_valid", {31'b0, o_valid}, 32'd0);
    check_valor("rst_mantiza", {24'b0, o_mantiza}, 32'd0);
    check_valor("rst_aviso", {31'b0, o_aviso_exponente}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Directed cases
    operacion(8'h00, 8'h00, 0);
    operacion(8'h80, 8'h00, 0);
    operacion(8'h00, 8'h80, 5);   // back-pressure with changing operands
    operacion(8'h00, 8'hFF, 0);
    for (int i = 0; i < 6; i++)
      operacion(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    operacion(8'hFF, 8'h00, 0);   // leaves 0xFF in the output register

    // Reset in the middle of RUN (after iteration 4)
    aceptar(8'h80, 8'h00);
    repeat (4) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    check_valor("midrun_rst_ready", {31'b0, o_ready}, 32'd1);
    check_valor("midrun_rst_valid", {31'b0, o_valid}, 32'd0);
    check_valor("midrun_rst_mantiza", {24'b0, o_mantiza}, 32'd0);
    check_valor("midrun_rst_aviso", {31'b0, o_aviso_exponente}, 32'd0);
`ifdef DIVISOR_MANTIZA_INEXACTO_EN
    check_valor("midrun_rst_inexacto", {31'b0, o_inexacto}, 32'd0);
`endif
    $display("reset asserted mid-RUN");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // First operation after reset
    operacion(8'h80, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
